sync_fifo_ctrl: RTL

Single-clock FIFO with built-in storage, pointer management, status flags and error detection. It is the parametrised successor to the bare dual-port FIFO memory: it adds pointer control, fill level, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, a synchronous flush, and a selectable read mode. It is used where producer and consumer share one clock domain.

---
 rtl/sync_fifo_ctrl_if.sv | 45 ++++
 rtl/sync_fifo_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// rtl/sync_fifo_ctrl_if.sv - producer/consumer handshake bundle for sync_fifo_ctrl
//
// Purpose: groups the request, data and status signals of sync_fifo_ctrl.
// master : the user side; drives wdata/winc/rinc/flush/err_clr and observes status.
// slave  : the FIFO side; drives rdata and all status flags.
//
// Signals:
//   wdata        [datawidth]    write data
//   winc                        write request
//   rinc                        read request
//   flush                       synchronous flush of all contents
//   err_clr                     synchronous clear of overflow/underflow
//   rdata        [datawidth]    read data
//   wfull, rempty               full / empty
//   almost_full, almost_empty   programmable threshold flags
//   count        [addr_width+1] fill level 0..DEPTH
//   overflow, underflow         sticky error flags
interface sync_fifo_ctrl_if #(
    parameter int datawidth  = 8,
    parameter int addr_width = 3
);
    logic [datawidth-1:0] wdata;
    logic                 winc;
    logic                 rinc;
    logic                 flush;
    logic                 err_clr;
    logic [datawidth-1:0] rdata;
    logic                 wfull;
    logic                 rempty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [addr_width:0]  count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wdata, winc, rinc, flush, err_clr,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, flush, err_clr,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with flags, flush, sticky errors and selectable read mode
//
// Purpose: single-clock FIFO of DEPTH = 1 << addr_width words with pointer
// management, fill level, almost-full/almost-empty thresholds, sticky
// overflow/underflow, synchronous flush and registered or fall-through read.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset (pointers, count, rdata, error flags)
//   fif    sync_fifo_ctrl_if.slave: wdata/winc/rinc/flush/err_clr in,
//          rdata/wfull/rempty/almost_full/almost_empty/count/overflow/underflow out
module sync_fifo_ctrl #(
    parameter int datawidth  = 8,
    parameter int addr_width = 3,
    parameter int fwft       = 0,
    parameter int afull_lvl  = 6,
    parameter int aempty_lvl = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_ctrl_if.slave fif
);
    localparam int DEPTH = 1 << addr_width;
    localparam int PW    = addr_width + 1;

    localparam logic [addr_width:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [addr_width:0] AFULL_C  = PW'(afull_lvl);
    localparam logic [addr_width:0] AEMPTY_C = PW'(aempty_lvl);
    localparam logic [addr_width:0] ONE_C    = PW'(1);

    // Pointers carry one extra wrap bit above the memory index.
    logic [addr_width:0]   wptr;
    logic [addr_width:0]   rptr;
    logic [addr_width:0]   count_q;
    logic [addr_width-1:0] widx;
    logic [addr_width-1:0] ridx;

    logic [datawidth-1:0]  mem [DEPTH];

    logic wfull_w;
    logic rempty_w;
    logic wr_ok;
    logic rd_ok;
    logic ovf_set;
    logic unf_set;
    logic ovf_q;
    logic unf_q;

    assign widx = wptr[addr_width-1:0];
    assign ridx = rptr[addr_width-1:0];

    // Flags decode the registered count only, so they change only after clk.
    assign wfull_w  = (count_q == DEPTH_C);
    assign rempty_w = (count_q == '0);

    assign wr_ok = fif.winc && !wfull_w  && !fif.flush;
    assign rd_ok = fif.rinc && !rempty_w && !fif.flush;

    // Attempts made while flushing are ignored entirely, errors included.
    assign ovf_set = fif.winc && wfull_w  && !fif.flush;
    assign unf_set = fif.rinc && rempty_w && !fif.flush;

    // Count is kept as its own register so the flag decodes see a single
    // registered source rather than a subtraction of two pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (fif.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE_C;
            end
            if (rd_ok) begin
                rptr <= rptr + ONE_C;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[widx] <= fif.wdata;
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (fif.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (fif.err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    generate
        if (fwft != 0) begin : g_fwft
            // Head word is shown directly; forced to zero when nothing is stored.
            assign fif.rdata = rempty_w ? '0 : mem[ridx];
        end else begin : g_reg
            logic [datawidth-1:0] rdata_q;

            // Holds through empty, refused reads and flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem[ridx];
                end
            end

            assign fif.rdata = rdata_q;
        end
    endgenerate

    assign fif.wfull        = wfull_w;
    assign fif.rempty       = rempty_w;
    assign fif.almost_full  = (count_q >= AFULL_C);
    assign fif.almost_empty = (count_q <= AEMPTY_C);
    assign fif.count        = count_q;
    assign fif.overflow     = ovf_q;
    assign fif.underflow    = unf_q;
endmodule
